// File: rtl/vga_pkg.sv
// Shared VGA timing constants and the lock state encoding used by the
// sync generator and the sync decoder.
package vga_pkg;

  localparam int CW      = 10;
  localparam int H_TOTAL = 800;
  localparam int V_TOTAL = 525;

  typedef enum logic [1:0] {
    SEARCH,
    TRACK,
    LOCKED
  } lock_state_t;

endpackage

// File: rtl/sync_edge_detect.sv
// Pixel-strobe gated edge detector for a synchronous sync input.
// The rise and fall outputs are combinational and only fire on an enabled pixel.
module sync_edge_detect (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic sig,
  output logic rise,
  output logic fall
);

  logic q;

  // Hold the previous pixel's sync level; only advance on the pixel strobe.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      q <= 1'b0;
    end else if (en) begin
      q <= sig;
    end
  end

  assign rise = en & sig & ~q;
  assign fall = en & ~sig & q;

endmodule

// File: rtl/vga_sync_decoder.sv
// Recovers pixel/line position from hs/vs pulses, measures line length and
// hsync width, and tracks lock against the nominal line/frame totals.
//
// state  | meaning
// SEARCH | no frame reference yet (after reset or an hsync timeout)
// TRACK  | frame reference found, counting consecutive good frames
// LOCKED | LOCK_FRAMES good frames seen, every line and frame still good
module vga_sync_decoder #(
  parameter int CW          = vga_pkg::CW,
  parameter int H_TOTAL     = vga_pkg::H_TOTAL,
  parameter int V_TOTAL     = vga_pkg::V_TOTAL,
  parameter int LOCK_FRAMES = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          pix_en,
  input  logic          hs_in,
  input  logic          vs_in,
  output logic [CW-1:0] h_count,
  output logic [CW-1:0] v_count,
  output logic [CW-1:0] line_len,
  output logic [CW-1:0] hs_width,
  output logic          new_line,
  output logic          new_frame,
  output logic          locked,
  output logic          err
);

  import vga_pkg::*;

  localparam logic [CW-1:0] CNT_MAX  = {CW{1'b1}};
  localparam logic [CW-1:0] CNT_PRE  = CNT_MAX - 1'b1;
  localparam logic [CW-1:0] H_TGT    = CW'(H_TOTAL);
  localparam logic [CW-1:0] V_TGT    = CW'(V_TOTAL);
  localparam logic [3:0]    LOCK_TGT = 4'(LOCK_FRAMES);

  logic hs_rise, hs_fall, vs_rise, vs_fall_unused;

  logic [CW-1:0] wid_cnt;
  logic          line_valid;
  logic          vs_pend;
  logic          lines_bad;

  logic [CW-1:0] h_inc, v_inc;
  logic          timeout, frame_evt, line_bad, v_bad, frame_good;

  lock_state_t state, state_next;
  logic [3:0]  good_cnt, good_next, good_inc;
  logic        err_next;

  sync_edge_detect u_hs_edge (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (pix_en),
    .sig   (hs_in),
    .rise  (hs_rise),
    .fall  (hs_fall)
  );

  sync_edge_detect u_vs_edge (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (pix_en),
    .sig   (vs_in),
    .rise  (vs_rise),
    .fall  (vs_fall_unused)
  );

  assign h_inc      = h_count + 1'b1;
  assign v_inc      = v_count + 1'b1;
  // Fires once, on the pixel that drives h_count into saturation.
  assign timeout    = pix_en & ~hs_rise & (h_count == CNT_PRE);
  assign frame_evt  = hs_rise & (vs_rise | vs_pend);
  assign line_bad   = hs_rise & line_valid & (h_inc != H_TGT);
  assign v_bad      = (v_inc != V_TGT);
  // The line ending on this edge belongs to the frame being closed.
  assign frame_good = ~v_bad & ~lines_bad & ~line_bad;
  assign good_inc   = good_cnt + 4'd1;

  // Position counters, line length and frame-start bookkeeping.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      h_count    <= '0;
      v_count    <= '0;
      line_len   <= '0;
      line_valid <= 1'b0;
      vs_pend    <= 1'b0;
      lines_bad  <= 1'b0;
      new_line   <= 1'b0;
      new_frame  <= 1'b0;
    end else begin
      new_line  <= hs_rise;
      new_frame <= frame_evt;
      if (pix_en) begin
        if (hs_rise) begin
          h_count <= '0;
          if (line_valid) begin
            line_len <= h_inc;
          end
          line_valid <= 1'b1;
          if (frame_evt) begin
            v_count <= '0;
          end else if (v_count != CNT_MAX) begin
            v_count <= v_inc;
          end
        end else begin
          if (h_count != CNT_MAX) begin
            h_count <= h_inc;
          end
          if (timeout) begin
            line_valid <= 1'b0;
          end
        end
        if (frame_evt) begin
          vs_pend <= 1'b0;
        end else if (vs_rise) begin
          vs_pend <= 1'b1;
        end
        if (frame_evt) begin
          lines_bad <= 1'b0;
        end else if (line_bad) begin
          lines_bad <= 1'b1;
        end
      end
    end
  end

  // Hsync pulse width: count high pixels from the rise, latch on the fall.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wid_cnt  <= '0;
      hs_width <= '0;
    end else if (pix_en) begin
      if (hs_rise) begin
        wid_cnt <= CW'(1);
      end else if (hs_in && wid_cnt != CNT_MAX) begin
        wid_cnt <= wid_cnt + 1'b1;
      end
      if (hs_fall) begin
        hs_width <= wid_cnt;
      end
    end
  end

  // Lock state, good-frame count and registered status outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= SEARCH;
      good_cnt <= '0;
      err      <= 1'b0;
      locked   <= 1'b0;
    end else begin
      state    <= state_next;
      good_cnt <= good_next;
      err      <= err_next;
      locked   <= (state_next == LOCKED);
    end
  end

  // Next-state logic. A frame that is bad only because of lines already
  // flagged does not raise a second err; it just fails to count as good.
  always_comb begin
    state_next = state;
    good_next  = good_cnt;
    err_next   = 1'b0;
    if (timeout) begin
      state_next = SEARCH;
      good_next  = '0;
      err_next   = (state != SEARCH);
    end else begin
      case (state)
        SEARCH: begin
          if (frame_evt) begin
            state_next = TRACK;
            good_next  = '0;
          end
        end
        TRACK: begin
          if (line_bad || (frame_evt && v_bad)) begin
            err_next  = 1'b1;
            good_next = '0;
          end else if (frame_evt) begin
            if (frame_good) begin
              good_next = good_inc;
              if (good_inc >= LOCK_TGT) begin
                state_next = LOCKED;
              end
            end else begin
              good_next = '0;
            end
          end
        end
        LOCKED: begin
          if (line_bad || (frame_evt && v_bad)) begin
            err_next   = 1'b1;
            good_next  = '0;
            state_next = TRACK;
          end
        end
        default: begin
          state_next = SEARCH;
          good_next  = '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_vga_sync_decoder.sv
// Directed bench for vga_sync_decoder. Uses a scaled-down raster
// (40 pixels x 10 lines, hsync 6 pixels, vsync 2 lines, CW=7) so every
// scenario, including the hsync timeout, runs in a few thousand clocks.
module tb_vga_sync_decoder;

  localparam int CW  = 7;
  localparam int H   = 40;
  localparam int V   = 10;
  localparam int HSW = 6;
  localparam int VSW = 2;
  localparam int LF  = 2;
  localparam int SAT = 127;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic pix_en = 1'b0;
  logic hs_in = 1'b0;
  logic vs_in = 1'b0;
  logic [CW-1:0] h_count, v_count, line_len, hs_width;
  logic new_line, new_frame, locked, err;

  always #5 clk = ~clk;

  vga_sync_decoder #(
    .CW          (CW),
    .H_TOTAL     (H),
    .V_TOTAL     (V),
    .LOCK_FRAMES (LF)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .pix_en    (pix_en),
    .hs_in     (hs_in),
    .vs_in     (vs_in),
    .h_count   (h_count),
    .v_count   (v_count),
    .line_len  (line_len),
    .hs_width  (hs_width),
    .new_line  (new_line),
    .new_frame (new_frame),
    .locked    (locked),
    .err       (err)
  );

  int n_checks = 0;
  int n_errors = 0;
  int gap = 1;

  // High-clock counts of each pulse output, sampled mid-cycle.
  int nl_cnt = 0;
  int nf_cnt = 0;
  int err_cnt = 0;
  always @(negedge clk) begin
    if (new_line)  nl_cnt++;
    if (new_frame) nf_cnt++;
    if (err)       err_cnt++;
  end

  // Outputs right after the most recent pixel edge, and at frame/mark points.
  logic p_nf, p_err, p_lk;
  logic [CW-1:0] p_len, p_v;
  logic s_nf, s_err, s_lk;
  logic [CW-1:0] s_len, s_v;
  logic m_err, m_lk;
  logic [CW-1:0] m_len;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic pix(input logic h, input logic v);
    hs_in  = h;
    vs_in  = v;
    pix_en = 1'b1;
    @(posedge clk); #1;
    p_nf  = new_frame;
    p_err = err;
    p_lk  = locked;
    p_len = line_len;
    p_v   = v_count;
    pix_en = 1'b0;
    for (int i = 1; i < gap; i++) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) pix(1'b0, 1'b0);
  endtask

  task automatic line(input int len, input int vs_from);
    for (int p = 0; p < len; p++) pix(p < HSW, p >= vs_from);
  endtask

  task automatic frame(input int short_line, input int mark_line);
    for (int l = 0; l < V; l++) begin
      for (int p = 0; p < ((l == short_line) ? H - 1 : H); p++) begin
        pix(p < HSW, l < VSW);
        if (p == 0 && l == 0) begin
          s_nf = p_nf; s_err = p_err; s_lk = p_lk; s_len = p_len; s_v = p_v;
        end
        if (p == 0 && l == mark_line) begin
          m_err = p_err; m_lk = p_lk; m_len = p_len;
        end
      end
    end
  endtask

  task automatic do_reset(input string tag);
    rst_n = 1'b0; pix_en = 1'b0; hs_in = 1'b0; vs_in = 1'b0;
    @(posedge clk); #1;
    check({tag, "_h"},   int'(h_count), 0);
    check({tag, "_v"},   int'(v_count), 0);
    check({tag, "_len"}, int'(line_len), 0);
    check({tag, "_wid"}, int'(hs_width), 0);
    check({tag, "_nl"},  int'(new_line), 0);
    check({tag, "_nf"},  int'(new_frame), 0);
    check({tag, "_lk"},  int'(locked), 0);
    check({tag, "_err"}, int'(err), 0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    #5_000_000;
    n_errors++;
    $display("FAIL watchdog got timeout expected finish");
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $fatal(1, "watchdog");
  end

  initial begin
    int e0, n0, f0;

    // Nominal timing, continuous pixel strobe.
    do_reset("rst0");
    gap = 1;
    idle(5);
    e0 = err_cnt; n0 = nl_cnt; f0 = nf_cnt;
    frame(-1, -1);
    check("f1_nf", int'(s_nf), 1);
    check("f1_v", int'(s_v), 0);
    check("f1_lk", int'(s_lk), 0);
    check("f1_unmeasured", int'(s_len), 0);
    frame(-1, -1);
    check("f2_lk", int'(s_lk), 0);
    frame(-1, -1);
    check("f3_lk", int'(s_lk), 1);
    check("nom_len", int'(line_len), H);
    check("nom_wid", int'(hs_width), HSW);
    check("nom_h", int'(h_count), H - 1);
    check("nom_v", int'(v_count), V - 1);
    check("nom_nl", nl_cnt - n0, 3 * V);
    check("nom_nf", nf_cnt - f0, 3);
    check("nom_err", err_cnt - e0, 0);

    // Short line while locked, then relock.
    e0 = err_cnt;
    frame(4, 5);
    check("short_lk_before", int'(s_lk), 1);
    check("short_err", int'(m_err), 1);
    check("short_lk", int'(m_lk), 0);
    check("short_len", int'(m_len), H - 1);
    frame(-1, -1);
    check("rl1_err", int'(s_err), 0);
    check("rl1_lk", int'(s_lk), 0);
    frame(-1, -1);
    check("rl2_lk", int'(s_lk), 0);
    frame(-1, -1);
    check("rl3_lk", int'(s_lk), 1);
    check("short_err_cnt", err_cnt - e0, 1);

    // Hsync timeout.
    e0 = err_cnt;
    idle(150);
    check("to_h", int'(h_count), SAT);
    check("to_err_cnt", err_cnt - e0, 1);
    check("to_lk", int'(locked), 0);
    check("to_len", int'(line_len), H);
    e0 = err_cnt;
    frame(-1, -1);
    check("to_f1_len", int'(s_len), H);
    check("to_f1_lk", int'(s_lk), 0);
    frame(-1, -1);
    check("to_f2_lk", int'(s_lk), 0);
    frame(-1, -1);
    check("to_f3_lk", int'(s_lk), 1);
    check("to_after_err", err_cnt - e0, 0);

    // Vsync rising mid-line: applied at the next hsync rise.
    for (int l = 0; l < 7; l++) line(H, (l < VSW) ? 0 : H);
    f0 = nf_cnt;
    line(H, 20);
    check("vsm_v", int'(v_count), 7);
    check("vsm_h", int'(h_count), H - 1);
    check("vsm_nf_cnt", nf_cnt - f0, 0);
    frame(-1, -1);
    check("vsm_nf", int'(s_nf), 1);
    check("vsm_v0", int'(s_v), 0);
    check("vsm_err", int'(s_err), 1);
    check("vsm_lk", int'(s_lk), 0);

    // Sparse pixel strobe: same results, pulses still one clock wide.
    do_reset("rst1");
    gap = 4;
    idle(5);
    e0 = err_cnt; n0 = nl_cnt; f0 = nf_cnt;
    frame(-1, -1);
    check("sp_f1_lk", int'(s_lk), 0);
    check("sp_f1_len", int'(s_len), 0);
    frame(-1, -1);
    check("sp_f2_lk", int'(s_lk), 0);
    frame(-1, -1);
    check("sp_f3_lk", int'(s_lk), 1);
    check("sp_len", int'(line_len), H);
    check("sp_wid", int'(hs_width), HSW);
    check("sp_h", int'(h_count), H - 1);
    check("sp_v", int'(v_count), V - 1);
    check("sp_nl", nl_cnt - n0, 3 * V);
    check("sp_nf", nf_cnt - f0, 3);
    check("sp_err", err_cnt - e0, 0);

    // Reset mid-frame while locked, then relock from scratch.
    gap = 1;
    for (int l = 0; l < 5; l++) line(H, (l < VSW) ? 0 : H);
    check("mid_lk", int'(locked), 1);
    do_reset("rst2");
    idle(5);
    frame(-1, -1);
    check("rr_f1_len", int'(s_len), 0);
    check("rr_f1_lk", int'(s_lk), 0);
    frame(-1, -1);
    check("rr_f2_lk", int'(s_lk), 0);
    frame(-1, -1);
    check("rr_f3_lk", int'(s_lk), 1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
